mem_addr_sequencer: RTL and testbench
=====================================

MEM_ADDR_SEQUENCER -- requirements
Module: mem_addr_sequencer

Interface
REQ-001 SHALL have parameter ADDRESSWIDTH, default 10: address width AW.
REQ-002 SHALL have parameter NCHAN, default 4: number of channel configuration slots; CW = max(1, $clog2(NCHAN)).
REQ-003 SHALL have parameter STEPWIDTH, default 4: address step width SW.
REQ-004 SHALL have port clk  in  1: clock, all logic on its rising edge.
REQ-005 SHALL have port rst  in  1: synchronous, active-high reset.
REQ-006 SHALL have port cfg_we  in  1: write the configuration slot selected by cfg_chan.
REQ-007 SHALL have port cfg_chan  in  CW: slot written by cfg_we.
REQ-008 SHALL have port cfg_base  in  AW: first address of the slot.
REQ-009 SHALL have port cfg_len  in  AW: words in the sequence minus one (0 = one word).
REQ-010 SHALL have port cfg_step  in  SW: address increment; value 0 is treated as 1.
REQ-011 SHALL have port cfg_loop  in  1: 1 = loop mode, 0 = one-shot mode.
REQ-012 SHALL have port start  in  1: launch the channel selected by start_chan.
REQ-013 SHALL have port start_chan  in  CW: channel to launch.
REQ-014 SHALL have port inc  in  1: advance the address by one step.
REQ-015 SHALL have port zero  in  1: restart the active sequence at its base address.
REQ-016 SHALL have port abort  in  1: stop the sequence immediately.
REQ-017 SHALL have port count_adr  out  AW: current memory address.
REQ-018 SHALL have port busy  out  1: a sequence is active, so count_adr is valid.
REQ-019 SHALL have port active_chan  out  CW: channel currently running.
REQ-020 SHALL have port done  out  1: one-cycle pulse when a one-shot sequence completes.
REQ-021 SHALL have port wrap  out  1: one-cycle pulse when a loop sequence returns to base.

Function
REQ-022 SHALL implement states IDLE and RUN only.
REQ-023 In IDLE, a start pulse SHALL latch slot start_chan into a working copy (base, len, step, loop), set count_adr = base and offset = 0, and enter RUN on the next edge.
REQ-024 In RUN, start SHALL be ignored.
REQ-025 In RUN, inc SHALL compute noff = offset + step at AW+1 bits.
REQ-026 If noff <= len, count_adr SHALL become base + noff modulo 2^AW.
REQ-027 If noff > len in loop mode, the block SHALL set offset to 0 and count_adr to base, pulse wrap, and stay in RUN.
REQ-028 If noff > len in one-shot mode, the block SHALL pulse done, go to IDLE and hold count_adr at the last issued address.
REQ-029 Priority in RUN SHALL be abort > zero > inc.
REQ-030 zero SHALL set offset to 0 and count_adr to base with no done or wrap pulse.
REQ-031 abort SHALL go to IDLE with no done or wrap pulse.
REQ-032 In IDLE, inc, zero and abort SHALL have no effect.
REQ-033 cfg_we SHALL update the stored slot in every state; the running copy SHALL remain unchanged until the next start.
REQ-034 cfg_we and start to the same slot in the same cycle SHALL launch using the old slot contents.
REQ-035 All outputs SHALL be registered; each change is visible one cycle after the causing input.

Reset
REQ-036 rst SHALL put the block in IDLE and force count_adr = 0, busy = 0, active_chan = 0, done = 0, wrap = 0.
REQ-037 rst SHALL clear every slot to base = 0, len = 0, step = 1, loop = 0.
REQ-038 rst asserted mid-sequence SHALL take priority over all other inputs.

Structure
REQ-039 A shared package SHALL hold the state enum (IDLE, RUN) and the slot struct type (base, len, step, loop).
REQ-040 The slot storage SHALL be a sub-module mem_addr_cfg_bank: NCHAN registered slots, one write port and one combinational read port.

Verification
REQ-041 One-shot: slot 1 = {base 100, len 3, step 1, loop 0}, start, 4 incs -> count_adr 100,101,102,103; 4th inc pulses done; busy falls; count_adr stays 103.
REQ-042 Loop with step: slot 2 = {base 10, len 5, step 2, loop 1}, 4 incs -> 12, 14, 10 with wrap pulse, then 12.
REQ-043 Address wrap-around: AW = 10, slot = {base 1022, len 3, step 1}, 3 incs -> 1023, 0, 1.
REQ-044 Priority: zero and inc in the same cycle at offset 2 -> count_adr = base; abort together with zero -> IDLE, no done pulse.
REQ-045 Configuration isolation: cfg_we rewrites the active slot mid-RUN -> sequence is unchanged; the next start uses the new values.
REQ-046 Reset: rst mid-RUN -> next cycle busy = 0 and count_adr = 0; a start without reconfiguration gives base 0, len 0, and a single inc pulses done.

Source files
------------

// File: rtl/mem_addr_sequencer_pkg.sv
// Shared types for the memory address sequencer: FSM states, the per-channel
// configuration slot and the channel-index width helper.
package mem_addr_sequencer_pkg;

    // Slot fields are stored at a fixed maximum width so one packed type fits
    // every ADDRESSWIDTH/STEPWIDTH up to these limits.
    localparam int SEQ_AW_MAX = 32;
    localparam int SEQ_SW_MAX = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    typedef struct packed {
        logic [SEQ_AW_MAX-1:0] base;
        logic [SEQ_AW_MAX-1:0] len;
        logic [SEQ_SW_MAX-1:0] step;
        logic                  loop;
    } slot_t;

    localparam slot_t SLOT_RESET = '{
        base: '0,
        len:  '0,
        step: SEQ_SW_MAX'(1),
        loop: 1'b0
    };

    function automatic int chan_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_addr_sequencer_if.sv
// Configuration, control and status bundle of the memory address sequencer.
interface mem_addr_sequencer_if
    import mem_addr_sequencer_pkg::*;
#(
    parameter int ADDRESSWIDTH = 10,
    parameter int NCHAN        = 4,
    parameter int STEPWIDTH    = 4
);
    localparam int AW = ADDRESSWIDTH;
    localparam int SW = STEPWIDTH;
    localparam int CW = chan_width(NCHAN);

    logic          cfg_we;
    logic [CW-1:0] cfg_chan;
    logic [AW-1:0] cfg_base;
    logic [AW-1:0] cfg_len;
    logic [SW-1:0] cfg_step;
    logic          cfg_loop;

    logic          start;
    logic [CW-1:0] start_chan;
    logic          inc;
    logic          zero;
    logic          abort;

    logic [AW-1:0] count_adr;
    logic          busy;
    logic [CW-1:0] active_chan;
    logic          done;
    logic          wrap;

    modport master (
        output cfg_we, cfg_chan, cfg_base, cfg_len, cfg_step, cfg_loop,
        output start, start_chan, inc, zero, abort,
        input  count_adr, busy, active_chan, done, wrap
    );

    modport slave (
        input  cfg_we, cfg_chan, cfg_base, cfg_len, cfg_step, cfg_loop,
        input  start, start_chan, inc, zero, abort,
        output count_adr, busy, active_chan, done, wrap
    );

endinterface

// File: rtl/mem_addr_cfg_bank.sv
// Per-channel configuration slots: registered storage, one write port and a
// combinational read port (reads see the contents before a same-cycle write).
module mem_addr_cfg_bank
    import mem_addr_sequencer_pkg::*;
#(
    parameter int NCHAN = 4,
    parameter int CW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [CW-1:0] wr_chan,
    input  slot_t         wr_slot,
    input  logic [CW-1:0] rd_chan,
    output slot_t         rd_slot
);

    slot_t slot_q [NCHAN];

    genvar gi;
    generate
        for (gi = 0; gi < NCHAN; gi++) begin : g_slot
            slot_t slot_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    slot_reg <= SLOT_RESET;
                end else if (wr_en && (wr_chan == CW'(gi))) begin
                    slot_reg <= wr_slot;
                end
            end

            assign slot_q[gi] = slot_reg;
        end
    endgenerate

    // Indices beyond NCHAN (non power-of-two bank) read back the reset slot.
    always_comb begin
        rd_slot = SLOT_RESET;
        for (int i = 0; i < NCHAN; i++) begin
            if (rd_chan == CW'(i)) begin
                rd_slot = slot_q[i];
            end
        end
    end

endmodule

// File: rtl/mem_addr_sequencer.sv
// Multi-channel memory address sequencer: launches a stored base/len/step
// sequence and steps through it in one-shot or loop mode.
module mem_addr_sequencer
    import mem_addr_sequencer_pkg::*;
#(
    parameter int ADDRESSWIDTH = 10,
    parameter int NCHAN        = 4,
    parameter int STEPWIDTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_addr_sequencer_if.slave   bus
);

    localparam int AW = ADDRESSWIDTH;
    localparam int SW = STEPWIDTH;
    localparam int CW = chan_width(NCHAN);

    slot_t         wr_slot;
    slot_t         rd_slot;
    logic [AW-1:0] rd_base;
    logic [AW-1:0] rd_len;
    logic [SW-1:0] rd_step;
    logic          rd_loop;

    seq_state_t    state_reg;
    logic [AW-1:0] base_reg;
    logic [AW-1:0] len_reg;
    logic [SW-1:0] step_reg;
    logic          loop_reg;
    logic [AW-1:0] offset_reg;

    logic [AW-1:0] count_adr_reg;
    logic          busy_reg;
    logic [CW-1:0] active_chan_reg;
    logic          done_reg;
    logic          wrap_reg;

    logic [AW:0]   noff_next;
    logic [AW-1:0] adr_next;

    always_comb begin
        wr_slot      = SLOT_RESET;
        wr_slot.base = SEQ_AW_MAX'(bus.cfg_base);
        wr_slot.len  = SEQ_AW_MAX'(bus.cfg_len);
        wr_slot.step = SEQ_SW_MAX'(bus.cfg_step);
        wr_slot.loop = bus.cfg_loop;
    end

    mem_addr_cfg_bank #(
        .NCHAN (NCHAN),
        .CW    (CW)
    ) u_cfg_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.cfg_we),
        .wr_chan (bus.cfg_chan),
        .wr_slot (wr_slot),
        .rd_chan (bus.start_chan),
        .rd_slot (rd_slot)
    );

    assign rd_base = rd_slot.base[AW-1:0];
    assign rd_len  = rd_slot.len[AW-1:0];
    assign rd_step = rd_slot.step[SW-1:0];
    assign rd_loop = rd_slot.loop;

    // The slot carries wider fields than this instance needs; fold the spare
    // bits into sinks so they are visibly consumed.
    generate
        if (AW < SEQ_AW_MAX) begin : g_unused_aw
            logic unused_aw_bits;
            assign unused_aw_bits = ^{rd_slot.base[SEQ_AW_MAX-1:AW],
                                      rd_slot.len[SEQ_AW_MAX-1:AW]};
        end
        if (SW < SEQ_SW_MAX) begin : g_unused_sw
            logic unused_sw_bits;
            assign unused_sw_bits = ^rd_slot.step[SEQ_SW_MAX-1:SW];
        end
    endgenerate

    // One extra bit on the offset sum so an overshoot past len is never
    // hidden by wrap-around.
    assign noff_next = {1'b0, offset_reg} + (AW+1)'(step_reg);
    assign adr_next  = base_reg + noff_next[AW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            base_reg        <= '0;
            len_reg         <= '0;
            step_reg        <= SW'(1);
            loop_reg        <= 1'b0;
            offset_reg      <= '0;
            count_adr_reg   <= '0;
            busy_reg        <= 1'b0;
            active_chan_reg <= '0;
            done_reg        <= 1'b0;
            wrap_reg        <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            wrap_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        base_reg        <= rd_base;
                        len_reg         <= rd_len;
                        step_reg        <= (rd_step == '0) ? SW'(1) : rd_step;
                        loop_reg        <= rd_loop;
                        offset_reg      <= '0;
                        count_adr_reg   <= rd_base;
                        busy_reg        <= 1'b1;
                        active_chan_reg <= bus.start_chan;
                        state_reg       <= RUN;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else if (bus.zero) begin
                        offset_reg    <= '0;
                        count_adr_reg <= base_reg;
                    end else if (bus.inc) begin
                        if (noff_next <= {1'b0, len_reg}) begin
                            offset_reg    <= noff_next[AW-1:0];
                            count_adr_reg <= adr_next;
                        end else if (loop_reg) begin
                            offset_reg    <= '0;
                            count_adr_reg <= base_reg;
                            wrap_reg      <= 1'b1;
                        end else begin
                            // count_adr keeps the last issued address.
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.count_adr   = count_adr_reg;
    assign bus.busy        = busy_reg;
    assign bus.active_chan = active_chan_reg;
    assign bus.done        = done_reg;
    assign bus.wrap        = wrap_reg;

endmodule

// File: tb/tb_mem_addr_sequencer.sv
// Directed self-checking bench for mem_addr_sequencer (AW=10, 4 channels, SW=4).
module tb_mem_addr_sequencer;

    localparam int AW  = 10;
    localparam int NCH = 4;
    localparam int SW  = 4;
    localparam int CW  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_addr_sequencer_if #(.ADDRESSWIDTH(AW), .NCHAN(NCH), .STEPWIDTH(SW)) bus ();

    mem_addr_sequencer #(.ADDRESSWIDTH(AW), .NCHAN(NCH), .STEPWIDTH(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.cfg_we = 1'b0; bus.cfg_chan = '0; bus.cfg_base = '0; bus.cfg_len = '0;
        bus.cfg_step = '0; bus.cfg_loop = 1'b0; bus.start = 1'b0; bus.start_chan = '0;
        bus.inc = 1'b0; bus.zero = 1'b0; bus.abort = 1'b0;
    endtask

    task automatic set_cfg(input int chan, input int base, input int len, input int step, input int lp);
        bus.cfg_chan = CW'(chan);
        bus.cfg_base = AW'(base);
        bus.cfg_len  = AW'(len);
        bus.cfg_step = SW'(step);
        bus.cfg_loop = (lp != 0);
        bus.cfg_we   = 1'b1;
    endtask

    task automatic cfg_write(input int chan, input int base, input int len, input int step, input int lp);
        set_cfg(chan, base, len, step, lp);
        tick();
        bus.cfg_we = 1'b0;
        $display("cfg   chan=%0d base=%0d len=%0d step=%0d loop=%0d", chan, base, len, step, lp);
    endtask

    task automatic launch(input int chan);
        bus.start_chan = CW'(chan);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        $display("start chan=%0d -> adr=%0d busy=%0b", chan, bus.count_adr, bus.busy);
    endtask

    task automatic do_inc();
        bus.inc = 1'b1;
        tick();
        bus.inc = 1'b0;
        $display("inc   -> adr=%0d busy=%0b done=%0b wrap=%0b", bus.count_adr, bus.busy, bus.done, bus.wrap);
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++; if (bus.count_adr !== '0) begin errors++; $display("FAIL reset_adr: got %0d expected 0", bus.count_adr); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
        checks++; if (bus.active_chan !== '0) begin errors++; $display("FAIL reset_chan: got %0d expected 0", bus.active_chan); end
        checks++; if ({bus.done, bus.wrap} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b expected 00", {bus.done, bus.wrap}); end
        bus.inc = 1'b1; bus.zero = 1'b1; bus.abort = 1'b1;
        tick();
        clear_inputs();
        checks++; if ({bus.busy, bus.count_adr} !== {1'b0, AW'(0)}) begin errors++; $display("FAIL idle_ignores_ctrl: got busy=%0b adr=%0d expected busy=0 adr=0", bus.busy, bus.count_adr); end
    endtask

    task automatic test_one_shot();
        int exp_adr [3];
        exp_adr = '{101, 102, 103};
        cfg_write(1, 100, 3, 1, 0);
        launch(1);
        checks++; if ({bus.busy, bus.count_adr} !== {1'b1, AW'(100)}) begin errors++; $display("FAIL one_shot_launch: got busy=%0b adr=%0d expected busy=1 adr=100", bus.busy, bus.count_adr); end
        checks++; if (bus.active_chan !== CW'(1)) begin errors++; $display("FAIL one_shot_chan: got %0d expected 1", bus.active_chan); end
        for (int i = 0; i < 3; i++) begin
            do_inc();
            checks++; if ({bus.done, bus.count_adr} !== {1'b0, AW'(exp_adr[i])}) begin errors++; $display("FAIL one_shot_step%0d: got done=%0b adr=%0d expected done=0 adr=%0d", i, bus.done, bus.count_adr, exp_adr[i]); end
        end
        do_inc();
        checks++; if ({bus.done, bus.busy, bus.count_adr} !== {1'b1, 1'b0, AW'(103)}) begin errors++; $display("FAIL one_shot_done: got done=%0b busy=%0b adr=%0d expected done=1 busy=0 adr=103", bus.done, bus.busy, bus.count_adr); end
        tick();
        checks++; if ({bus.done, bus.count_adr} !== {1'b0, AW'(103)}) begin errors++; $display("FAIL one_shot_hold: got done=%0b adr=%0d expected done=0 adr=103", bus.done, bus.count_adr); end
    endtask

    task automatic test_loop_step();
        int exp_adr [4];
        logic exp_wrap [4];
        exp_adr  = '{12, 14, 10, 12};
        exp_wrap = '{1'b0, 1'b0, 1'b1, 1'b0};
        cfg_write(2, 10, 5, 2, 1);
        launch(2);
        for (int i = 0; i < 4; i++) begin
            do_inc();
            checks++; if ({bus.wrap, bus.done, bus.busy, bus.count_adr} !== {exp_wrap[i], 1'b0, 1'b1, AW'(exp_adr[i])}) begin errors++; $display("FAIL loop_step%0d: got wrap=%0b done=%0b busy=%0b adr=%0d expected wrap=%0b done=0 busy=1 adr=%0d", i, bus.wrap, bus.done, bus.busy, bus.count_adr, exp_wrap[i], exp_adr[i]); end
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checks++; if ({bus.busy, bus.done, bus.wrap} !== 3'b000) begin errors++; $display("FAIL loop_abort: got busy=%0b done=%0b wrap=%0b expected 000", bus.busy, bus.done, bus.wrap); end
    endtask

    task automatic test_addr_wrap();
        int exp_adr [3];
        exp_adr = '{1023, 0, 1};
        cfg_write(0, 1022, 3, 1, 0);
        launch(0);
        for (int i = 0; i < 3; i++) begin
            do_inc();
            checks++; if (bus.count_adr !== AW'(exp_adr[i])) begin errors++; $display("FAIL addr_wrap%0d: got %0d expected %0d", i, bus.count_adr, exp_adr[i]); end
        end
        do_inc();
        checks++; if ({bus.done, bus.count_adr} !== {1'b1, AW'(1)}) begin errors++; $display("FAIL addr_wrap_done: got done=%0b adr=%0d expected done=1 adr=1", bus.done, bus.count_adr); end
        // step 0 behaves as step 1
        cfg_write(3, 5, 2, 0, 0);
        launch(3);
        do_inc();
        checks++; if (bus.count_adr !== AW'(6)) begin errors++; $display("FAIL step_zero_a: got %0d expected 6", bus.count_adr); end
        do_inc();
        checks++; if (bus.count_adr !== AW'(7)) begin errors++; $display("FAIL step_zero_b: got %0d expected 7", bus.count_adr); end
        do_inc();
        checks++; if ({bus.done, bus.count_adr} !== {1'b1, AW'(7)}) begin errors++; $display("FAIL step_zero_done: got done=%0b adr=%0d expected done=1 adr=7", bus.done, bus.count_adr); end
    endtask

    task automatic test_priority();
        cfg_write(3, 200, 7, 1, 0);
        launch(3);
        do_inc(); do_inc();
        checks++; if (bus.count_adr !== AW'(202)) begin errors++; $display("FAIL prio_pre: got %0d expected 202", bus.count_adr); end
        bus.zero = 1'b1; bus.inc = 1'b1;
        tick();
        bus.zero = 1'b0; bus.inc = 1'b0;
        checks++; if ({bus.busy, bus.wrap, bus.done, bus.count_adr} !== {1'b1, 1'b0, 1'b0, AW'(200)}) begin errors++; $display("FAIL prio_zero_inc: got busy=%0b wrap=%0b done=%0b adr=%0d expected busy=1 wrap=0 done=0 adr=200", bus.busy, bus.wrap, bus.done, bus.count_adr); end
        do_inc();
        checks++; if (bus.count_adr !== AW'(201)) begin errors++; $display("FAIL prio_after_zero: got %0d expected 201", bus.count_adr); end
        launch(1);
        checks++; if ({bus.active_chan, bus.count_adr} !== {CW'(3), AW'(201)}) begin errors++; $display("FAIL start_in_run: got chan=%0d adr=%0d expected chan=3 adr=201", bus.active_chan, bus.count_adr); end
        bus.abort = 1'b1; bus.zero = 1'b1;
        tick();
        bus.abort = 1'b0; bus.zero = 1'b0;
        checks++; if ({bus.busy, bus.done, bus.wrap} !== 3'b000) begin errors++; $display("FAIL prio_abort_zero: got busy=%0b done=%0b wrap=%0b expected 000", bus.busy, bus.done, bus.wrap); end
    endtask

    task automatic test_cfg_isolation();
        launch(1);
        do_inc();
        cfg_write(1, 300, 1, 1, 0);
        checks++; if (bus.count_adr !== AW'(101)) begin errors++; $display("FAIL iso_write: got %0d expected 101", bus.count_adr); end
        do_inc(); do_inc();
        checks++; if ({bus.busy, bus.count_adr} !== {1'b1, AW'(103)}) begin errors++; $display("FAIL iso_old_seq: got busy=%0b adr=%0d expected busy=1 adr=103", bus.busy, bus.count_adr); end
        do_inc();
        checks++; if ({bus.done, bus.count_adr} !== {1'b1, AW'(103)}) begin errors++; $display("FAIL iso_old_done: got done=%0b adr=%0d expected done=1 adr=103", bus.done, bus.count_adr); end
        launch(1);
        checks++; if (bus.count_adr !== AW'(300)) begin errors++; $display("FAIL iso_new_base: got %0d expected 300", bus.count_adr); end
        do_inc(); do_inc();
        checks++; if ({bus.done, bus.count_adr} !== {1'b1, AW'(301)}) begin errors++; $display("FAIL iso_new_done: got done=%0b adr=%0d expected done=1 adr=301", bus.done, bus.count_adr); end
        // write and launch the same slot together: the old contents win
        set_cfg(1, 500, 0, 1, 0);
        bus.start_chan = CW'(1); bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.cfg_we = 1'b0;
        checks++; if ({bus.busy, bus.count_adr} !== {1'b1, AW'(300)}) begin errors++; $display("FAIL same_cycle_old: got busy=%0b adr=%0d expected busy=1 adr=300", bus.busy, bus.count_adr); end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        launch(1);
        checks++; if (bus.count_adr !== AW'(500)) begin errors++; $display("FAIL same_cycle_new: got %0d expected 500", bus.count_adr); end
        do_inc();
        checks++; if ({bus.done, bus.busy} !== 2'b10) begin errors++; $display("FAIL len0_done: got done=%0b busy=%0b expected done=1 busy=0", bus.done, bus.busy); end
    endtask

    task automatic test_reset_mid_run();
        launch(2);
        do_inc();
        checks++; if (bus.count_adr !== AW'(12)) begin errors++; $display("FAIL rst_pre: got %0d expected 12", bus.count_adr); end
        rst = 1'b1; bus.inc = 1'b1;
        tick();
        rst = 1'b0; bus.inc = 1'b0;
        checks++; if ({bus.busy, bus.count_adr, bus.active_chan, bus.wrap} !== {1'b0, AW'(0), CW'(0), 1'b0}) begin errors++; $display("FAIL rst_mid_run: got busy=%0b adr=%0d chan=%0d wrap=%0b expected 0 0 0 0", bus.busy, bus.count_adr, bus.active_chan, bus.wrap); end
        launch(2);
        checks++; if ({bus.busy, bus.count_adr} !== {1'b1, AW'(0)}) begin errors++; $display("FAIL rst_slot_cleared: got busy=%0b adr=%0d expected busy=1 adr=0", bus.busy, bus.count_adr); end
        do_inc();
        checks++; if ({bus.done, bus.busy, bus.count_adr} !== {1'b1, 1'b0, AW'(0)}) begin errors++; $display("FAIL rst_single_inc: got done=%0b busy=%0b adr=%0d expected done=1 busy=0 adr=0", bus.done, bus.busy, bus.count_adr); end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_loop_step();
        test_addr_wrap();
        test_priority();
        test_cfg_isolation();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
